// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial engine: FSM encodings and default sizing.
package factorial_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_WIDTH_DEF    = 4;
    // 12! = 479001600 is the largest factorial that fits in 32 bits.
    localparam int MAX_N_DEF      = 12;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MULT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

endpackage

// File: rtl/factorial_dp.sv
// Datapath for the factorial engine: operand, down-counter, running product
// and result registers, driven by load/step/commit/clear strobes.
module factorial_dp
    import factorial_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_WIDTH    = N_WIDTH_DEF,
    parameter int MAX_N      = MAX_N_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  commit,
    input  logic                  clear,
    input  logic [N_WIDTH-1:0]    n,
    output logic                  n_over,
    output logic                  n_le1,
    output logic                  cnt_is2,
    output logic [DATA_WIDTH-1:0] result
);

    logic [N_WIDTH-1:0]    n_reg;
    logic [N_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] mult_p;

    simple_multiplier #(.WIDTH(DATA_WIDTH)) u_mult (
        .a (prod),
        .b (DATA_WIDTH'(cnt)),
        .p (mult_p)
    );

    // Status flags for the controller, all derived from registered state.
    assign n_over  = int'(n_reg) > MAX_N;
    assign n_le1   = n_reg <= N_WIDTH'(1);
    assign cnt_is2 = cnt == N_WIDTH'(2);

    // Register updates; 0! and 1! bypass the multiplier since prod*cnt
    // would give 0 for n = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg  <= '0;
            cnt    <= '0;
            prod   <= DATA_WIDTH'(1);
            result <= '0;
        end else begin
            if (load) begin
                n_reg <= n;
                cnt   <= n;
                prod  <= DATA_WIDTH'(1);
            end
            if (step) begin
                prod <= mult_p;
                cnt  <= cnt - N_WIDTH'(1);
            end
            if (commit) begin
                result <= n_le1 ? DATA_WIDTH'(1) : mult_p;
            end
            if (clear) begin
                result <= '0;
            end
        end
    end

endmodule

// File: rtl/simple_multiplier.sv
// Combinational multiplier keeping only the low WIDTH bits of the product.
module simple_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    // Truncating product; callers guarantee no overflow in normal use.
    assign p = a * b;

endmodule

// File: rtl/factorial_engine.sv
// Factorial engine top: handshake FSM steering the factorial datapath.
//
//  state | meaning
//  IDLE  | waiting for go; result holds last value
//  CHECK | classify latched n: too large, trivial (0/1) or iterate
//  MULT  | one prod*cnt step per cycle until cnt reaches 2
//  DONE  | result valid; wait for go to drop
//  ERR   | n exceeded MAX_N, result 0; wait for go to drop
module factorial_engine
    import factorial_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_WIDTH    = N_WIDTH_DEF,
    parameter int MAX_N      = MAX_N_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [N_WIDTH-1:0]    n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] result
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       load;
    logic       step;
    logic       commit;
    logic       clear;
    logic       n_over;
    logic       n_le1;
    logic       cnt_is2;

    factorial_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_WIDTH    (N_WIDTH),
        .MAX_N      (MAX_N)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .commit  (commit),
        .clear   (clear),
        .n       (n),
        .n_over  (n_over),
        .n_le1   (n_le1),
        .cnt_is2 (cnt_is2),
        .result  (result)
    );

    // Next-state and datapath strobe decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        clear     = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    load      = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (n_over) begin
                    clear     = 1'b1;
                    state_nxt = S_ERR;
                end else if (n_le1) begin
                    commit    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                step = 1'b1;
                if (cnt_is2) begin
                    commit    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (!go) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Moore outputs decoded from the state register only.
    assign busy = (state == S_CHECK) || (state == S_MULT);
    assign done = (state == S_DONE) || (state == S_ERR);
    assign err  = (state == S_ERR);

endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench for factorial_engine: table-driven handshakes plus
// hand-written reset-mid-run and operand-change sequences.
module tb_factorial_engine;

    logic        clk;
    logic        rst;
    logic        go;
    logic [3:0]  n;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;

    int tests  = 0;
    int failed = 0;

    factorial_engine dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  nv;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_edges;  // edges after acceptance edge until done seen
        int          exp_busy;   // sampled cycles with busy high
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Accept go at edge E0, then follow the run to done; returns edge count
    // after E0 at which done first appears and number of busy samples.
    task automatic start_and_wait(input logic [3:0] nv, output int edges, output int busy_cnt,
                                  output logic ok);
        @(negedge clk);
        n  = nv;
        go = 1'b1;
        @(posedge clk);
        #1;
        edges    = 0;
        busy_cnt = 0;
        ok       = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                edges = k;
                ok    = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   edges;
        int   bcnt;
        logic ok;
        start_and_wait(v.nv, edges, bcnt, ok);
        check($sformatf("v%0d_n%0d_done_seen", idx, v.nv), 64'(ok), 64'(1));
        check($sformatf("v%0d_n%0d_latency", idx, v.nv), 64'(edges), 64'(v.exp_edges));
        check($sformatf("v%0d_n%0d_busy_cycles", idx, v.nv), 64'(bcnt), 64'(v.exp_busy));
        check($sformatf("v%0d_n%0d_result", idx, v.nv), 64'(result), 64'(v.exp_res));
        check($sformatf("v%0d_n%0d_err", idx, v.nv), 64'(err), 64'(v.exp_err));
        @(posedge clk);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_n%0d_done_held", idx, v.nv), 64'({done, busy, err}),
              64'({1'b1, 1'b0, v.exp_err}));
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_n%0d_idle_after_drop", idx, v.nv), 64'({done, busy, err}), 64'(0));
        check($sformatf("v%0d_n%0d_result_kept", idx, v.nv), 64'(result), 64'(v.exp_res));
    endtask

    initial begin
        int   edges;
        int   bcnt;
        logic ok;

        vecs[0] = '{4'd5,  32'd120,       1'b0, 5,  5};
        vecs[1] = '{4'd0,  32'd1,         1'b0, 1,  1};
        vecs[2] = '{4'd1,  32'd1,         1'b0, 1,  1};
        vecs[3] = '{4'd12, 32'h1C8CFC00,  1'b0, 12, 12};
        vecs[4] = '{4'd13, 32'd0,         1'b1, 1,  1};
        vecs[5] = '{4'd15, 32'd0,         1'b1, 1,  1};
        vecs[6] = '{4'd3,  32'd6,         1'b0, 3,  3};
        vecs[7] = '{4'd2,  32'd2,         1'b0, 2,  2};
        vecs[8] = '{4'd7,  32'd5040,      1'b0, 7,  7};
        vecs[9] = '{4'd4,  32'd24,        1'b0, 4,  4};

        rst = 1'b1;
        go  = 1'b0;
        n   = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, err}), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_go", 64'({busy, done, err}), 64'(0));

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of MULT for n = 10.
        @(negedge clk);
        n  = 4'd10;
        go = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(busy), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs", 64'({busy, done, err}), 64'(0));
        check("midrun_reset_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", 64'({busy, done, err}), 64'(0));
        run_vec('{4'd4, 32'd24, 1'b0, 4, 4}, 10);

        // Operand change while busy is ignored; go held after done never restarts.
        @(negedge clk);
        n  = 4'd6;
        go = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 4'd9;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("nchange_done_seen", 64'(ok), 64'(1));
        check("nchange_result", 64'(result), 64'(720));
        repeat (6) @(posedge clk);
        #1;
        check("go_held_stays_done", 64'({done, busy, err}), 64'(3'b100));
        check("go_held_result", 64'(result), 64'(720));
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        check("go_drop_idle", 64'(done), 64'(0));
        start_and_wait(4'd9, edges, bcnt, ok);
        check("restart_done_seen", 64'(ok), 64'(1));
        check("restart_latency", 64'(edges), 64'(9));
        check("restart_result", 64'(result), 64'(362880));
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
